// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, 2-bit counter encodings, predictor FSM states and counter update
package mips_pkg;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;
  typedef enum logic {INIT, RUN} state_e;
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    return taken ? (cnt == ST ? ST : cnt + 2'd1) : (cnt == SNT ? SNT : cnt - 2'd1);
  endfunction
endpackage

// File: rtl/branch_predict_if.sv
// branch_predict_if: fetch lookup, decode resolve and redirect/stats bundle of the branch predictor
//   fetch : PC_fetch, Instr_fetch -> Pred_taken, Pred_target
//   train : Res_valid, Res_PC, Res_taken, Res_pred, Res_target
//   status: Ready, Mispredict, Redirect_PC, Br_count, Miss_count
interface branch_predict_if;
  logic        Ready;
  logic [31:0] PC_fetch;
  logic [31:0] Instr_fetch;
  logic        Pred_taken;
  logic [31:0] Pred_target;
  logic        Res_valid;
  logic [31:0] Res_PC;
  logic        Res_taken;
  logic        Res_pred;
  logic [31:0] Res_target;
  logic        Mispredict;
  logic [31:0] Redirect_PC;
  logic [31:0] Br_count;
  logic [31:0] Miss_count;
  modport master (
    output PC_fetch, Instr_fetch, Res_valid, Res_PC, Res_taken, Res_pred, Res_target,
    input  Ready, Pred_taken, Pred_target, Mispredict, Redirect_PC, Br_count, Miss_count
  );
  modport slave (
    input  PC_fetch, Instr_fetch, Res_valid, Res_PC, Res_taken, Res_pred, Res_target,
    output Ready, Pred_taken, Pred_target, Mispredict, Redirect_PC, Br_count, Miss_count
  );
endinterface

// File: rtl/bht_sat2.sv
// bht_sat2: table of 2-bit saturating counters, one async read port, one write port
//   clk                  : rising-edge clock
//   init_en_i/init_idx_i : init sweep write of WNT (takes priority over training)
//   upd_en_i/upd_idx_i/upd_taken_i : saturating training update
//   rd_idx_i/rd_cnt_o    : zero-latency lookup, returns the pre-update value
module bht_sat2
  import mips_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             init_en_i,
  input  logic [IDX_W-1:0] init_idx_i,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_cnt_o
);
  logic [1:0] cnt_q [2**IDX_W];
  assign rd_cnt_o = cnt_q[rd_idx_i];
  always_ff @(posedge clk) begin
    if (init_en_i) cnt_q[init_idx_i] <= WNT;
    else if (upd_en_i) cnt_q[upd_idx_i] <= sat_update(cnt_q[upd_idx_i], upd_taken_i);
  end
endmodule

// File: rtl/branch_predict.sv
// branch_predict: fetch-stage 2-bit branch direction predictor with training and mispredict redirect
//   CLK, RESET_N : clock and synchronous active-low reset
//   bp (slave)   : fetch lookup, decode resolve, mispredict/redirect and statistics
module branch_predict
  import mips_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input logic             CLK,
  input logic             RESET_N,
  branch_predict_if.slave bp
);
  state_e           state_q;
  logic [IDX_W-1:0] init_idx_q;
  logic             ready_q;
  logic             mis_q;
  logic [31:0]      redir_q;
  logic [31:0]      br_cnt_q;
  logic [31:0]      miss_cnt_q;
  logic [5:0]       opc;
  logic [4:0]       rt;
  logic             is_cond;
  logic             is_jmp;
  logic             pred_taken;
  logic [1:0]       rd_cnt;
  logic [31:0]      pc4;
  logic [31:0]      br_tgt;
  logic [31:0]      jmp_tgt;
  logic             upd;
  logic             miss;
  assign opc = bp.Instr_fetch[31:26];
  assign rt  = bp.Instr_fetch[20:16];
  // REGIMM only counts as a branch for BLTZ/BGEZ/BLTZAL/BGEZAL
  assign is_cond = (opc == OP_REGIMM && rt inside {5'b00000, 5'b00001, 5'b10000, 5'b10001}) ||
                   opc inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ};
  assign is_jmp  = opc == OP_J || opc == OP_JAL;
  assign pc4     = bp.PC_fetch + 32'd4;
  assign br_tgt  = pc4 + {{14{bp.Instr_fetch[15]}}, bp.Instr_fetch[15:0], 2'b00};
  assign jmp_tgt = {pc4[31:28], bp.Instr_fetch[25:0], 2'b00};
  assign pred_taken = ready_q && (is_jmp || (is_cond && rd_cnt >= WT));
  assign upd  = ready_q && bp.Res_valid;
  assign miss = upd && (bp.Res_taken != bp.Res_pred);
  assign bp.Pred_taken  = pred_taken;
  assign bp.Pred_target = !pred_taken ? pc4 : is_jmp ? jmp_tgt : br_tgt;
  assign bp.Ready       = ready_q;
  assign bp.Mispredict  = mis_q;
  assign bp.Redirect_PC = redir_q;
  assign bp.Br_count    = br_cnt_q;
  assign bp.Miss_count  = miss_cnt_q;
  bht_sat2 #(.IDX_W(IDX_W)) u_bht (
    .clk         (CLK),
    .init_en_i   (state_q == INIT),
    .init_idx_i  (init_idx_q),
    .upd_en_i    (upd),
    .upd_idx_i   (bp.Res_PC[IDX_W+1:2]),
    .upd_taken_i (bp.Res_taken),
    .rd_idx_i    (bp.PC_fetch[IDX_W+1:2]),
    .rd_cnt_o    (rd_cnt)
  );
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= INIT;
      init_idx_q <= '0;
      ready_q    <= 1'b0;
      mis_q      <= 1'b0;
      redir_q    <= '0;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (state_q == INIT) begin
        init_idx_q <= init_idx_q + 1'b1;
        if (&init_idx_q) begin
          state_q <= RUN;
          ready_q <= 1'b1;
        end
      end
      mis_q <= miss;
      // not-taken redirect skips the delay slot
      if (miss) redir_q <= bp.Res_taken ? bp.Res_target : bp.Res_PC + 32'd8;
      br_cnt_q   <= br_cnt_q + 32'(upd);
      miss_cnt_q <= miss_cnt_q + 32'(miss);
    end
  end
endmodule

// File: tb/tb_branch_predict.sv
// tb_branch_predict: directed and randomized checks of branch_predict against a behavioural model
module tb_branch_predict;
  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  int checks = 0;
  int failures = 0;
  localparam logic [31:0] BEQ_I4 = 32'h1000_0004;
  localparam logic [31:0] J_I    = 32'h0800_0040;
  localparam logic [31:0] JAL_I  = 32'h0C00_0040;
  branch_predict_if bp();
  branch_predict #(.IDX_W(6)) dut (.CLK(CLK), .RESET_N(RESET_N), .bp(bp));
  always #5 CLK = ~CLK;
  int          m_cnt [64];
  bit          m_ready;
  int          m_sweep;
  bit          m_mis;
  logic [31:0] m_redir;
  logic [31:0] m_br;
  logic [31:0] m_miss;

  task automatic tick();
    int i;
    @(posedge CLK);
    if (!RESET_N) begin
      m_ready = 0; m_sweep = 0; m_mis = 0; m_redir = 0; m_br = 0; m_miss = 0;
    end else if (!m_ready) begin
      m_sweep++;
      if (m_sweep == 64) begin
        m_ready = 1;
        foreach (m_cnt[k]) m_cnt[k] = 1;
      end
    end else begin
      m_mis = bp.Res_valid && (bp.Res_taken != bp.Res_pred);
      if (m_mis) begin
        m_redir = bp.Res_taken ? bp.Res_target : bp.Res_PC + 8;
        m_miss++;
      end
      if (bp.Res_valid) begin
        m_br++;
        i = int'(bp.Res_PC[7:2]);
        m_cnt[i] = bp.Res_taken ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3) : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
      end
    end
    #1;
  endtask

  function automatic void model_pred(input logic [31:0] pc, input logic [31:0] ins,
                                     output logic t, output logic [31:0] tg);
    logic [31:0] pc4;
    logic [5:0]  op;
    logic [4:0]  rt;
    bit          cond, jmp;
    int          off;
    pc4 = pc + 4;
    op = ins[31:26];
    rt = ins[20:16];
    cond = (op == 6'd1 && (rt == 0 || rt == 1 || rt == 16 || rt == 17)) || (op >= 6'd4 && op <= 6'd7);
    jmp = op == 6'd2 || op == 6'd3;
    t = m_ready && (jmp || (cond && m_cnt[pc[7:2]] >= 2));
    off = $signed(ins[15:0]);
    tg = !t ? pc4 : jmp ? {pc4[31:28], ins[25:0], 2'b00} : pc4 + 32'(off * 4);
  endfunction

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic pr, input logic [31:0] tg);
    bp.Res_valid = 1; bp.Res_PC = pc; bp.Res_taken = tk; bp.Res_pred = pr; bp.Res_target = tg;
    tick();
    bp.Res_valid = 0;
  endtask

  task automatic test_reset();
    RESET_N = 0;
    bp.PC_fetch = 0; bp.Instr_fetch = 0; bp.Res_valid = 0; bp.Res_PC = 0;
    bp.Res_taken = 0; bp.Res_pred = 0; bp.Res_target = 0;
    tick(); tick();
    checks++; if (bp.Ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", bp.Ready); end
    checks++; if (bp.Mispredict !== 1'b0) begin failures++; $display("FAIL reset_mispredict got=%0b exp=0", bp.Mispredict); end
    checks++; if (bp.Redirect_PC !== 32'h0) begin failures++; $display("FAIL reset_redirect got=%h exp=0", bp.Redirect_PC); end
    checks++; if ({bp.Br_count, bp.Miss_count} !== 64'h0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", bp.Br_count, bp.Miss_count); end
  endtask

  task automatic test_init();
    RESET_N = 1;
    bp.PC_fetch = 32'h100; bp.Instr_fetch = BEQ_I4;
    bp.Res_valid = 1; bp.Res_PC = 32'h100; bp.Res_taken = 1; bp.Res_pred = 0; bp.Res_target = 32'h114;
    for (int i = 1; i <= 64; i++) begin
      tick();
      checks++; if (bp.Ready !== (i == 64)) begin failures++; $display("FAIL init_ready cycle=%0d got=%0b exp=%0b", i, bp.Ready, i == 64); end
      if (i == 10) begin
        checks++; if ({bp.Pred_taken, bp.Pred_target} !== {1'b0, 32'h104}) begin failures++; $display("FAIL init_lookup got=%0b/%h exp=0/00000104", bp.Pred_taken, bp.Pred_target); end
      end
    end
    bp.Res_valid = 0;
    checks++; if ({bp.Mispredict, bp.Br_count, bp.Miss_count} !== 65'h0) begin failures++; $display("FAIL init_ignores_resolve got=%0b/%0d/%0d exp=0/0/0", bp.Mispredict, bp.Br_count, bp.Miss_count); end
  endtask

  task automatic test_lookup_train();
    bp.PC_fetch = 32'h100; bp.Instr_fetch = BEQ_I4;
    #1;
    checks++; if ({bp.Pred_taken, bp.Pred_target} !== {1'b0, 32'h104}) begin failures++; $display("FAIL beq_wnt got=%0b/%h exp=0/00000104", bp.Pred_taken, bp.Pred_target); end
    resolve(32'h100, 1, 0, 32'h114);
    #1;
    checks++; if ({bp.Pred_taken, bp.Pred_target} !== {1'b1, 32'h114}) begin failures++; $display("FAIL beq_wt got=%0b/%h exp=1/00000114", bp.Pred_taken, bp.Pred_target); end
  endtask

  task automatic test_saturation();
    bp.PC_fetch = 32'h100; bp.Instr_fetch = BEQ_I4;
    repeat (4) resolve(32'h100, 1, 1, 32'h114);
    resolve(32'h100, 0, 1, 32'h114);
    #1;
    checks++; if (bp.Pred_taken !== 1'b1) begin failures++; $display("FAIL sat_high got=%0b exp=1", bp.Pred_taken); end
    resolve(32'h100, 0, 1, 32'h114);
    #1;
    checks++; if (bp.Pred_taken !== 1'b0) begin failures++; $display("FAIL sat_wnt got=%0b exp=0", bp.Pred_taken); end
    resolve(32'h100, 0, 0, 32'h114);
    resolve(32'h100, 0, 0, 32'h114);
    resolve(32'h100, 1, 0, 32'h114);
    #1;
    checks++; if (bp.Pred_taken !== 1'b0) begin failures++; $display("FAIL sat_low_step1 got=%0b exp=0", bp.Pred_taken); end
    resolve(32'h100, 1, 0, 32'h114);
    #1;
    checks++; if (bp.Pred_taken !== 1'b1) begin failures++; $display("FAIL sat_low_step2 got=%0b exp=1", bp.Pred_taken); end
  endtask

  task automatic test_jump();
    bp.PC_fetch = 32'h0040_0010; bp.Instr_fetch = J_I;
    #1;
    checks++; if ({bp.Pred_taken, bp.Pred_target} !== {1'b1, 32'h100}) begin failures++; $display("FAIL jump_j got=%0b/%h exp=1/00000100", bp.Pred_taken, bp.Pred_target); end
    bp.Instr_fetch = JAL_I;
    #1;
    checks++; if ({bp.Pred_taken, bp.Pred_target} !== {1'b1, 32'h100}) begin failures++; $display("FAIL jump_jal got=%0b/%h exp=1/00000100", bp.Pred_taken, bp.Pred_target); end
    bp.Instr_fetch = BEQ_I4;
    #1;
    checks++; if ({bp.Pred_taken, bp.Pred_target} !== {1'b0, 32'h0040_0014}) begin failures++; $display("FAIL jump_table_untouched got=%0b/%h exp=0/00400014", bp.Pred_taken, bp.Pred_target); end
  endtask

  task automatic test_same_cycle();
    bp.PC_fetch = 32'h14; bp.Instr_fetch = BEQ_I4;
    bp.Res_valid = 1; bp.Res_PC = 32'h14; bp.Res_taken = 1; bp.Res_pred = 0; bp.Res_target = 32'h28;
    #1;
    checks++; if (bp.Pred_taken !== 1'b0) begin failures++; $display("FAIL same_cycle_old got=%0b exp=0", bp.Pred_taken); end
    tick();
    bp.Res_valid = 0;
    #1;
    checks++; if ({bp.Pred_taken, bp.Pred_target} !== {1'b1, 32'h28}) begin failures++; $display("FAIL same_cycle_new got=%0b/%h exp=1/00000028", bp.Pred_taken, bp.Pred_target); end
  endtask

  task automatic test_random();
    logic [31:0] r, pc, rpc, etg;
    logic [5:0]  op;
    logic [1:0]  rs;
    logic        et;
    int          sel;
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      sel = $urandom_range(0, 8);
      op = sel == 0 ? 6'd1 : sel == 1 ? 6'd4 : sel == 2 ? 6'd5 : sel == 3 ? 6'd6 :
           sel == 4 ? 6'd7 : sel == 5 ? 6'd2 : sel == 6 ? 6'd3 : r[31:26];
      bp.Instr_fetch = {op, r[25:0]};
      if (op == 6'd1 && $urandom_range(0, 1) == 1) begin
        rs = 2'($urandom_range(0, 3));
        bp.Instr_fetch[20:16] = {rs[1], 3'b000, rs[0]};
      end
      pc = $urandom(); pc[7:2] = 6'($urandom_range(0, 7)); pc[1:0] = 2'b00;
      rpc = $urandom(); rpc[7:2] = 6'($urandom_range(0, 7)); rpc[1:0] = 2'b00;
      bp.PC_fetch = pc;
      bp.Res_valid = $urandom_range(0, 2) != 0;
      bp.Res_PC = rpc;
      bp.Res_taken = 1'($urandom_range(0, 1));
      bp.Res_pred = 1'($urandom_range(0, 1));
      bp.Res_target = $urandom();
      #1;
      model_pred(pc, bp.Instr_fetch, et, etg);
      checks++; if (bp.Pred_taken !== et) begin failures++; $display("FAIL rand_pred_taken n=%0d pc=%h ins=%h got=%0b exp=%0b", n, pc, bp.Instr_fetch, bp.Pred_taken, et); end
      checks++; if (bp.Pred_target !== etg) begin failures++; $display("FAIL rand_pred_target n=%0d pc=%h ins=%h got=%h exp=%h", n, pc, bp.Instr_fetch, bp.Pred_target, etg); end
      tick();
      checks++; if (bp.Mispredict !== m_mis) begin failures++; $display("FAIL rand_mispredict n=%0d got=%0b exp=%0b", n, bp.Mispredict, m_mis); end
      if (m_mis) begin
        checks++; if (bp.Redirect_PC !== m_redir) begin failures++; $display("FAIL rand_redirect n=%0d got=%h exp=%h", n, bp.Redirect_PC, m_redir); end
      end
      checks++; if ({bp.Br_count, bp.Miss_count} !== {m_br, m_miss}) begin failures++; $display("FAIL rand_counts n=%0d got=%0d/%0d exp=%0d/%0d", n, bp.Br_count, bp.Miss_count, m_br, m_miss); end
    end
    bp.Res_valid = 0;
  endtask

  task automatic test_reset_mid();
    bp.PC_fetch = 32'h100; bp.Instr_fetch = BEQ_I4;
    repeat (3) resolve(32'h100, 1, 0, 32'h114);
    #1;
    checks++; if (bp.Pred_taken !== 1'b1) begin failures++; $display("FAIL midrst_pretrain got=%0b exp=1", bp.Pred_taken); end
    bp.Res_valid = 1; bp.Res_PC = 32'h1C4; bp.Res_taken = 0; bp.Res_pred = 1;
    tick();
    RESET_N = 0;
    tick();
    bp.Res_valid = 0;
    checks++; if ({bp.Ready, bp.Mispredict, bp.Br_count, bp.Miss_count} !== 66'h0) begin failures++; $display("FAIL midrst_cleared got=%0b/%0b/%0d/%0d exp=0/0/0/0", bp.Ready, bp.Mispredict, bp.Br_count, bp.Miss_count); end
    RESET_N = 1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      checks++; if (bp.Ready !== (i == 64)) begin failures++; $display("FAIL midrst_ready cycle=%0d got=%0b exp=%0b", i, bp.Ready, i == 64); end
    end
    checks++; if ({bp.Pred_taken, bp.Pred_target} !== {1'b0, 32'h104}) begin failures++; $display("FAIL midrst_resweep got=%0b/%h exp=0/00000104", bp.Pred_taken, bp.Pred_target); end
  endtask

  task automatic test_mispredict();
    resolve(32'h200, 0, 1, 32'h1234_5678);
    checks++; if ({bp.Mispredict, bp.Redirect_PC} !== {1'b1, 32'h208}) begin failures++; $display("FAIL mis_pulse got=%0b/%h exp=1/00000208", bp.Mispredict, bp.Redirect_PC); end
    checks++; if ({bp.Br_count, bp.Miss_count} !== {32'd1, 32'd1}) begin failures++; $display("FAIL mis_counts got=%0d/%0d exp=1/1", bp.Br_count, bp.Miss_count); end
    tick();
    checks++; if (bp.Mispredict !== 1'b0) begin failures++; $display("FAIL mis_clear got=%0b exp=0", bp.Mispredict); end
    resolve(32'h200, 1, 1, 32'h1234_5678);
    checks++; if ({bp.Mispredict, bp.Br_count, bp.Miss_count} !== {1'b0, 32'd2, 32'd1}) begin failures++; $display("FAIL mis_correct got=%0b/%0d/%0d exp=0/2/1", bp.Mispredict, bp.Br_count, bp.Miss_count); end
  endtask

  task automatic test_back_to_back();
    resolve(32'h300, 1, 0, 32'h4000);
    checks++; if ({bp.Mispredict, bp.Redirect_PC} !== {1'b1, 32'h4000}) begin failures++; $display("FAIL b2b_first got=%0b/%h exp=1/00004000", bp.Mispredict, bp.Redirect_PC); end
    resolve(32'h340, 0, 1, 32'h0);
    checks++; if ({bp.Mispredict, bp.Redirect_PC} !== {1'b1, 32'h348}) begin failures++; $display("FAIL b2b_second got=%0b/%h exp=1/00000348", bp.Mispredict, bp.Redirect_PC); end
    tick();
    checks++; if (bp.Mispredict !== 1'b0) begin failures++; $display("FAIL b2b_clear got=%0b exp=0", bp.Mispredict); end
    checks++; if ({bp.Br_count, bp.Miss_count} !== {32'd4, 32'd3}) begin failures++; $display("FAIL b2b_counts got=%0d/%0d exp=4/3", bp.Br_count, bp.Miss_count); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_lookup_train();
    test_saturation();
    test_jump();
    test_same_cycle();
    test_random();
    test_reset_mid();
    test_mispredict();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
